// File: rtl/mixed_radix_timer_if.sv
// mixed_radix_timer_if: control/status bundle for the mixed-radix timer.
//   master: drives enable, up_down, clear, load, load_value; observes count, tick, wrap, done
//   slave : the timer side, mirror image of master
interface mixed_radix_timer_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_BITS = 4
);
    logic                             enable;
    logic                             up_down;
    logic                             clear;
    logic                             load;
    logic [NUM_DIGITS*DIGIT_BITS-1:0] load_value;
    logic [NUM_DIGITS*DIGIT_BITS-1:0] count;
    logic                             tick;
    logic                             wrap;
    logic                             done;

    modport master (
        output enable, up_down, clear, load, load_value,
        input  count, tick, wrap, done
    );

    modport slave (
        input  enable, up_down, clear, load, load_value,
        output count, tick, wrap, done
    );
endinterface

// File: rtl/mixed_radix_timer.sv
// mixed_radix_timer: cascaded multi-digit up/down timer with per-digit radix and built-in tick prescaler.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : mixed_radix_timer_if.slave
//         enable/up_down/clear/load/load_value in; count/tick/wrap/done out (all registered)
module mixed_radix_timer #(
    parameter int                               NUM_DIGITS   = 4,
    parameter int                               DIGIT_BITS   = 4,
    parameter logic [NUM_DIGITS*DIGIT_BITS-1:0] DIGIT_RADIX  = 16'h6A6A,
    parameter int                               CLK_HZ       = 100_000_000,
    parameter int                               TICK_HZ      = 1,
    parameter bit                               STOP_AT_ZERO = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    mixed_radix_timer_if.slave  bus
);
    localparam int W   = NUM_DIGITS * DIGIT_BITS;
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2 || DIV * TICK_HZ != CLK_HZ) begin : g_bad_div
        $error("mixed_radix_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
    end

    logic [PW-1:0] r_pre;
    logic [W-1:0]  r_count;
    logic          r_tick;
    logic          r_wrap;
    logic          r_done;

    logic [W-1:0]  w_max;
    logic [W-1:0]  w_clamped;
    logic [W-1:0]  w_up;
    logic [W-1:0]  w_dn;
    logic [W-1:0]  w_next;
    logic          w_carry;
    logic          w_borrow;
    logic          w_hold;
    logic          w_wrap;
    logic          w_step;

    // Ripple carry/borrow across digits. A radix field of 0 stands for 2^DIGIT_BITS,
    // so radix-1 naturally becomes all ones. After the loop w_carry means "all digits
    // at max" and w_borrow means "all digits zero".
    always_comb begin
        w_max     = '0;
        w_clamped = '0;
        w_up      = '0;
        w_dn      = '0;
        w_carry   = 1'b1;
        w_borrow  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_max[i*DIGIT_BITS +: DIGIT_BITS]     = DIGIT_RADIX[i*DIGIT_BITS +: DIGIT_BITS] - 1'b1;
            w_clamped[i*DIGIT_BITS +: DIGIT_BITS] =
                (bus.load_value[i*DIGIT_BITS +: DIGIT_BITS] > w_max[i*DIGIT_BITS +: DIGIT_BITS])
                ? w_max[i*DIGIT_BITS +: DIGIT_BITS] : bus.load_value[i*DIGIT_BITS +: DIGIT_BITS];
            w_up[i*DIGIT_BITS +: DIGIT_BITS] = !w_carry ? r_count[i*DIGIT_BITS +: DIGIT_BITS] :
                (r_count[i*DIGIT_BITS +: DIGIT_BITS] == w_max[i*DIGIT_BITS +: DIGIT_BITS])
                ? '0 : r_count[i*DIGIT_BITS +: DIGIT_BITS] + 1'b1;
            w_dn[i*DIGIT_BITS +: DIGIT_BITS] = !w_borrow ? r_count[i*DIGIT_BITS +: DIGIT_BITS] :
                (r_count[i*DIGIT_BITS +: DIGIT_BITS] == '0)
                ? w_max[i*DIGIT_BITS +: DIGIT_BITS] : r_count[i*DIGIT_BITS +: DIGIT_BITS] - 1'b1;
            w_carry  = w_carry  && (r_count[i*DIGIT_BITS +: DIGIT_BITS] == w_max[i*DIGIT_BITS +: DIGIT_BITS]);
            w_borrow = w_borrow && (r_count[i*DIGIT_BITS +: DIGIT_BITS] == '0);
        end
    end

    // A down-step from all zero either holds (tick still pulses) or wraps to all max.
    assign w_hold = !bus.up_down && w_borrow && STOP_AT_ZERO;
    assign w_next = bus.up_down ? w_up : (w_hold ? r_count : w_dn);
    assign w_wrap = bus.up_down ? w_carry : (w_borrow && !STOP_AT_ZERO);
    assign w_step = bus.enable && (r_pre == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst || bus.clear) begin
            r_pre   <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.load) begin
            r_pre   <= '0;
            r_count <= w_clamped;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= w_step;
            r_wrap <= w_step && w_wrap;
            if (bus.enable)
                r_pre <= w_step ? '0 : r_pre + 1'b1;
            if (w_step) begin
                r_count <= w_next;
                if (!bus.up_down && w_next == '0)
                    r_done <= 1'b1;
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tick  = r_tick;
    assign bus.wrap  = r_wrap;
    assign bus.done  = r_done;
endmodule
